phase_reporter: RTL and testbench
=================================

# phase_reporter

Transmit-side companion to the host command receiver. On request, the block snapshots the current per-channel phase table and error status, frames them as one fixed-length packet, and pushes the bytes into the proto245 TX FIFO (FPGA -> host). It never writes a partial packet into a FIFO that lacks room for the whole packet. It sits beside the receiver in `top`, sharing `clk`/`rst` and driving `txfifo_wr`/`txfifo_data`.

## Interface
- `NUM_CHANNELS`, default 2: number of phase entries; 1..250.
- `PHASE_W`, default 8: phase width; must be ≤ 8. Each phase is zero-extended into one byte.
- `DATA_W`, default 8: FIFO byte width; fixed at 8.
- `TX_FIFO_SIZE`, default 4096: TX FIFO depth in bytes.
- `TX_FIFO_LOAD_W`, default 13: width of `txfifo_load`; equals $clog2(TX_FIFO_SIZE)+1.
- `HEADER`, default 8'hA5: packet start byte.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `phases`  in  [PHASE_W-1:0] x NUM_CHANNELS  current phase table from the receiver.
- `read_error`  in  1  error pulse/level from the receiver.
- `report_req`  in  1  single-cycle request to send one packet.
- `txfifo_load`  in  TX_FIFO_LOAD_W  current TX FIFO occupancy.
- `txfifo_full`  in  1  TX FIFO full.
- `txfifo_data`  out  8  byte to write.
- `txfifo_wr`  out  1  write strobe. A byte is accepted on every cycle this signal is high.
- `busy`  out  1  packet in progress.
- `drop_count`  out  8  saturating count of requests that were dropped.

## Operation
- Packet length L = NUM_CHANNELS + 4. Byte order:
  - `HEADER`
  - NUM_CHANNELS (count byte)
  - phases[0] .. phases[N-1]
  - status byte: bit0 = sticky read_error, bit1 = drop-since-last flag, bits 7:2 = 0
  - checksum = XOR of all preceding L-1 bytes
- FSM states: IDLE, HDR, CNT, PH, STAT, CSUM.
  - IDLE -> HDR when a request is present (`report_req` or the pending flag) and free space ≥ L.
  - Free space = TX_FIFO_SIZE − `txfifo_load`, computed at TX_FIFO_LOAD_W+1 bits with no wrap.
  - Insufficient space: stay in IDLE, consume the request, increment `drop_count`, set the drop flag.
  - Each state advances only on a cycle where its byte is accepted (valid & !`txfifo_full`).
  - PH holds a channel index from 0 to N-1 and leaves for STAT after index N-1 is accepted.
  - CSUM -> IDLE.
- Snapshot: all `phases` are registered on the IDLE->HDR transition. Later changes to `phases` do not affect the packet in progress.
- Sticky error: set on any cycle `read_error`=1.
  - The status byte carries the value present at STAT entry.
  - When STAT is accepted, the sticky bit and the drop flag clear, except that a `read_error` on that same cycle leaves the sticky bit set.
- Requests while busy: one-deep pending flag.
  - A request while busy with pending clear sets pending.
  - A request while pending is already set increments `drop_count` and sets the drop flag.
  - A pending request starts a packet on the first IDLE cycle (subject to the space check).
- `drop_count` saturates at 255 and clears only on reset.
- Checksum accumulator is cleared at HDR entry and XORs in each byte as it is accepted.

## Timing
- Reset values:
  - State = IDLE; `busy`=0; `txfifo_wr`=0; `txfifo_data`=0.
  - `drop_count`=0; pending, sticky error, drop flag and checksum = 0.
- `txfifo_data` is registered.
- `txfifo_wr` = byte_valid & !`txfifo_full`. This is the only combinational path, and `txfifo_wr` is never high while `txfifo_full`=1.
- Latency: `report_req` sampled high in IDLE at cycle N -> `HEADER` written at cycle N+1. With no backpressure the packet occupies cycles N+1..N+L back-to-back.
- `busy` is high from cycle N+1 through the cycle the checksum is accepted, and is low the following cycle. A new packet may start the cycle after CSUM is accepted.
- Backpressure: while `txfifo_full` is high, `txfifo_data` holds its value and the state holds; there is no byte loss or duplication.
- Boundary case: if `txfifo_load` leaves exactly L bytes free, the packet starts.
- Reset mid-packet: the block returns to IDLE on the next edge and writes nothing further. A truncated packet already in the FIFO is acceptable; the host resyncs on `HEADER`.

## Test plan
- Basic packet:
  - Stimulus: `phases`={8'h10,8'h80}, no error, load=0, pulse `report_req`.
  - Required: writes A5 02 10 80 00 37 on 6 consecutive cycles; `busy` high for 6 cycles.
- Backpressure:
  - Stimulus: same as basic, with `txfifo_full` high for 3 cycles after the count byte.
  - Required: same 6 bytes, no duplicates, `txfifo_wr`=0 during full; the packet ends 3 cycles later.
- Sticky error:
  - Stimulus: pulse `read_error` while idle, then request twice.
  - Required: first packet status 8'h01; second packet status 8'h00; checksums correct.
- Space drop:
  - Stimulus: `txfifo_load`=4091 (free 5 < L=6), request.
  - Required: no writes; `drop_count`=1.
  - Follow-up: set load=0 and request again. Required: status 8'h02.
- Pending:
  - Stimulus: three requests during one packet.
  - Required: exactly two packets back-to-back; `drop_count`=1.
- Reset mid-packet:
  - Stimulus: assert `rst` after the 3rd byte.
  - Required: `txfifo_wr`=0 from the next edge, all outputs at reset values, and a fresh request afterwards produces a full correct packet.

Source files
------------

// File: rtl/phase_reporter.sv
// Frames a snapshot of the per-channel phase table plus error status into one
// fixed-length packet and writes it into the TX FIFO, only when the whole packet fits.
module phase_reporter #(
    parameter int          NUM_CHANNELS   = 2,
    parameter int          PHASE_W        = 8,
    parameter int          DATA_W         = 8,
    parameter int          TX_FIFO_SIZE   = 4096,
    parameter int          TX_FIFO_LOAD_W = 13,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CHANNELS*PHASE_W-1:0]  phases,
    input  logic                             read_error,
    input  logic                             report_req,
    input  logic [TX_FIFO_LOAD_W-1:0]        txfifo_load,
    input  logic                             txfifo_full,
    output logic [DATA_W-1:0]                txfifo_data,
    output logic                             txfifo_wr,
    output logic                             busy,
    output logic [7:0]                       drop_count
);

    localparam int SPACE_W = TX_FIFO_LOAD_W + 1;
    localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [SPACE_W-1:0] FIFO_SIZE_S = SPACE_W'(TX_FIFO_SIZE);
    localparam logic [SPACE_W-1:0] PKT_LEN_S   = SPACE_W'(NUM_CHANNELS + 4);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [7:0]         CNT_BYTE    = 8'(NUM_CHANNELS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_CNT  = 3'd2,
        S_PH   = 3'd3,
        S_STAT = 3'd4,
        S_CSUM = 3'd5
    } state_t;

    state_t             state_r;
    logic [7:0]         snap_r [NUM_CHANNELS];
    logic [IDX_W-1:0]   ch_idx_r;
    logic [7:0]         csum_r;
    logic               pending_r;
    logic               sticky_r;
    logic               drop_flag_r;

    logic               accept_s;
    logic               space_ok_s;
    logic               start_s;
    logic               stat_done_s;
    logic               drop_event_s;
    logic [1:0]         drop_inc_s;
    logic               pending_next_s;
    logic [8:0]         drop_sum_s;
    logic [7:0]         drop_count_next_s;
    logic [SPACE_W-1:0] load_ext_s;

    function automatic logic [7:0] phase_byte(input logic [NUM_CHANNELS*PHASE_W-1:0] tbl,
                                              input int idx);
        return 8'(tbl[idx*PHASE_W +: PHASE_W]);
    endfunction

    function automatic logic [7:0] status_byte(input logic sticky, input logic dflag);
        return {6'b000000, dflag, sticky};
    endfunction

    // The write strobe is the only combinational output: a byte goes out whenever one is staged and the FIFO has room.
    assign txfifo_wr = busy & ~txfifo_full;

    // Request arbitration: space check, drop accounting and the one-deep pending slot.
    always_comb begin
        accept_s       = busy & ~txfifo_full;
        load_ext_s     = {1'b0, txfifo_load};
        space_ok_s     = (load_ext_s <= FIFO_SIZE_S) &&
                         ((FIFO_SIZE_S - load_ext_s) >= PKT_LEN_S);
        start_s        = 1'b0;
        drop_inc_s     = 2'd0;
        pending_next_s = pending_r;
        if (state_r == S_IDLE) begin
            if (report_req || pending_r) begin
                if (space_ok_s) begin
                    start_s        = 1'b1;
                    // A fresh request coinciding with a pending one waits for the next packet.
                    pending_next_s = report_req & pending_r;
                end else begin
                    drop_inc_s     = {1'b0, report_req} + {1'b0, pending_r};
                    pending_next_s = 1'b0;
                end
            end else begin
                pending_next_s = 1'b0;
            end
        end else begin
            if (report_req && pending_r) begin
                drop_inc_s = 2'd1;
            end else if (report_req) begin
                pending_next_s = 1'b1;
            end else begin
                pending_next_s = pending_r;
            end
        end
        drop_event_s      = (drop_inc_s != 2'd0);
        stat_done_s       = (state_r == S_STAT) && accept_s;
        drop_sum_s        = {1'b0, drop_count} + {7'b0000000, drop_inc_s};
        drop_count_next_s = (drop_sum_s > 9'd255) ? 8'hFF : drop_sum_s[7:0];
    end

    // Packet sequencer, status flags and staged output byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy        <= 1'b0;
            txfifo_data <= 8'h00;
            drop_count  <= 8'h00;
            pending_r   <= 1'b0;
            sticky_r    <= 1'b0;
            drop_flag_r <= 1'b0;
            csum_r      <= 8'h00;
            ch_idx_r    <= IDX_W'(0);
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                snap_r[i] <= 8'h00;
            end
        end else begin
            pending_r   <= pending_next_s;
            drop_count  <= drop_count_next_s;
            sticky_r    <= stat_done_s ? read_error : (sticky_r | read_error);
            drop_flag_r <= drop_event_s | (drop_flag_r & ~stat_done_s);
            if (accept_s) begin
                csum_r <= csum_r ^ txfifo_data;
            end
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        state_r     <= S_HDR;
                        busy        <= 1'b1;
                        txfifo_data <= HEADER;
                        csum_r      <= 8'h00;
                        ch_idx_r    <= IDX_W'(0);
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            snap_r[i] <= phase_byte(phases, i);
                        end
                    end
                end
                S_HDR: begin
                    if (accept_s) begin
                        state_r     <= S_CNT;
                        txfifo_data <= CNT_BYTE;
                    end
                end
                S_CNT: begin
                    if (accept_s) begin
                        state_r     <= S_PH;
                        ch_idx_r    <= IDX_W'(0);
                        txfifo_data <= snap_r[0];
                    end
                end
                S_PH: begin
                    if (accept_s) begin
                        if (ch_idx_r == LAST_IDX) begin
                            state_r     <= S_STAT;
                            txfifo_data <= status_byte(sticky_r | read_error,
                                                       drop_flag_r | drop_event_s);
                        end else begin
                            ch_idx_r    <= ch_idx_r + IDX_W'(1);
                            txfifo_data <= snap_r[ch_idx_r + IDX_W'(1)];
                        end
                    end
                end
                S_STAT: begin
                    if (accept_s) begin
                        state_r     <= S_CSUM;
                        txfifo_data <= csum_r ^ txfifo_data;
                    end
                end
                S_CSUM: begin
                    if (accept_s) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_reporter.sv
// Self-checking bench for phase_reporter: directed scenarios plus randomized
// traffic compared against a packet-level reference model.
module tb_phase_reporter;

    localparam int L = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] phases;
    logic        read_error;
    logic        report_req;
    logic [12:0] txfifo_load;
    logic        txfifo_full;
    logic [7:0]  txfifo_data;
    logic        txfifo_wr;
    logic        busy;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_full_viol = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit m_sticky, m_dflag;
    int m_drops;

    phase_reporter dut (
        .clk(clk), .rst(rst), .phases(phases), .read_error(read_error),
        .report_req(report_req), .txfifo_load(txfifo_load), .txfifo_full(txfifo_full),
        .txfifo_data(txfifo_data), .txfifo_wr(txfifo_wr), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Byte monitor: every accepted write lands in got_q.
    always @(negedge clk) begin
        if (txfifo_wr === 1'b1) begin
            got_q.push_back(txfifo_data);
            if (txfifo_full !== 1'b0) wr_full_viol++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req;
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
    endtask

    task automatic expect_packet(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] status);
        logic [7:0] b[5];
        logic [7:0] cs;
        b = '{8'hA5, 8'd2, p0, p1, status};
        cs = 8'h00;
        foreach (b[i]) begin
            exp_q.push_back(b[i]);
            cs = cs ^ b[i];
        end
        exp_q.push_back(cs);
    endtask

    // Reference model for one request seen while idle.
    task automatic model_request;
        int free;
        free = 4096 - int'(txfifo_load);
        if (free >= L) begin
            expect_packet(phases[7:0], phases[15:8], {6'b000000, m_dflag, m_sticky});
            m_sticky = 1'b0;
            m_dflag  = 1'b0;
        end else begin
            if (m_drops < 255) m_drops++;
            m_dflag = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 300) begin
            tick();
            c++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_timeout: busy=%b required 0", name, busy);
        else n_pass++;
    endtask

    task automatic do_reset;
        rst = 1'b1; phases = 16'h0000; read_error = 1'b0; report_req = 1'b0;
        txfifo_load = 13'd0; txfifo_full = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        m_sticky = 1'b0; m_dflag = 1'b0; m_drops = 0;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (txfifo_wr !== 1'b0) $display("FAIL reset_wr: got %b required 0", txfifo_wr); else n_pass++;
        n_checks++; if (txfifo_data !== 8'h00) $display("FAIL reset_data: got %h required 00", txfifo_data); else n_pass++;
        n_checks++; if (drop_count !== 8'h00) $display("FAIL reset_drop: got %0d required 0", drop_count); else n_pass++;
    endtask

    task automatic test_basic;
        logic [7:0] b[6];
        b = '{8'hA5, 8'h02, 8'h10, 8'h80, 8'h00, 8'h37};
        phases = {8'h80, 8'h10};
        pulse_req();
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (txfifo_wr !== 1'b1 || txfifo_data !== b[k] || busy !== 1'b1)
                $display("FAIL basic_byte%0d: wr=%b data=%h busy=%b required wr=1 data=%h busy=1",
                         k, txfifo_wr, txfifo_data, busy, b[k]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || txfifo_wr !== 1'b0)
            $display("FAIL basic_end: busy=%b wr=%b required 0 0", busy, txfifo_wr);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [7:0] d[9];
        d = '{8'hA5, 8'h02, 8'h10, 8'h10, 8'h10, 8'h10, 8'h80, 8'h00, 8'h37};
        phases = {8'h80, 8'h10};
        tick();
        pulse_req();
        for (int k = 0; k < 9; k++) begin
            txfifo_full = (k >= 2 && k <= 4);
            #1;
            n_checks++;
            if (txfifo_wr !== !txfifo_full || txfifo_data !== d[k] || busy !== 1'b1)
                $display("FAIL bp_cycle%0d: wr=%b data=%h busy=%b required wr=%b data=%h busy=1",
                         k, txfifo_wr, txfifo_data, busy, !txfifo_full, d[k]);
            else n_pass++;
            tick();
        end
        txfifo_full = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL bp_end: busy=%b required 0", busy); else n_pass++;
    endtask

    task automatic compare_streams(input string name);
        n_checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s_len: got %0d bytes required %0d", name, got_q.size(), exp_q.size());
        else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("FAIL %s_byte%0d: got %h required %h", name, i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_sticky;
        got_q.delete(); exp_q.delete();
        tick();
        read_error = 1'b1; tick(); read_error = 1'b0;
        m_sticky = 1'b1;
        phases = 16'($urandom);
        model_request(); pulse_req(); wait_idle("sticky1");
        tick();
        phases = 16'($urandom);
        model_request(); pulse_req(); wait_idle("sticky2");
        compare_streams("sticky");
    endtask

    task automatic test_space_drop;
        got_q.delete(); exp_q.delete();
        tick();
        txfifo_load = 13'd4091;
        model_request(); pulse_req();
        n_checks++; if (busy !== 1'b0) $display("FAIL space_nostart: busy=%b required 0", busy); else n_pass++;
        repeat (3) tick();
        n_checks++; if (got_q.size() != 0) $display("FAIL space_nowrite: got %0d bytes required 0", got_q.size()); else n_pass++;
        n_checks++; if (drop_count !== 8'(m_drops)) $display("FAIL space_drop: got %0d required %0d", drop_count, m_drops); else n_pass++;
        txfifo_load = 13'd0; phases = 16'($urandom);
        model_request(); pulse_req(); wait_idle("space_retry"); tick();
        txfifo_load = 13'd4090; phases = 16'($urandom);
        model_request(); pulse_req();
        n_checks++; if (busy !== 1'b1) $display("FAIL space_exact: busy=%b required 1", busy); else n_pass++;
        wait_idle("space_exact"); tick();
        txfifo_load = 13'd4096;
        model_request(); pulse_req(); tick();
        n_checks++; if (drop_count !== 8'(m_drops)) $display("FAIL space_full_drop: got %0d required %0d", drop_count, m_drops); else n_pass++;
        txfifo_load = 13'd0;
        compare_streams("space");
    endtask

    task automatic test_pending;
        int c;
        int drops_before;
        got_q.delete(); exp_q.delete();
        tick();
        drops_before = int'(drop_count);
        phases = 16'($urandom);
        // The third request is dropped before the first packet reaches its status byte.
        if (m_drops < 255) m_drops++;
        m_dflag = 1'b1;
        model_request();
        model_request();
        pulse_req();
        report_req = 1'b1; tick(); report_req = 1'b0;
        tick();
        report_req = 1'b1; tick(); report_req = 1'b0;
        c = 3;
        while (got_q.size() < 12 && c < 100) begin
            tick();
            c++;
        end
        n_checks++;
        if (c != 13) $display("FAIL pending_timing: took %0d cycles required 13", c); else n_pass++;
        wait_idle("pending");
        n_checks++;
        if (int'(drop_count) != drops_before + 1)
            $display("FAIL pending_drop: got %0d required %0d", drop_count, drops_before + 1);
        else n_pass++;
        compare_streams("pending");
    endtask

    task automatic test_random;
        int c;
        got_q.delete(); exp_q.delete();
        for (int it = 0; it < 25; it++) begin
            tick();
            phases = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                read_error = 1'b1; tick(); read_error = 1'b0;
                m_sticky = 1'b1;
            end
            case ($urandom_range(0, 3))
                0: txfifo_load = 13'd0;
                1: txfifo_load = 13'd4090;
                2: txfifo_load = 13'd4091;
                default: txfifo_load = 13'($urandom_range(0, 4096));
            endcase
            model_request();
            pulse_req();
            c = 0;
            while (busy === 1'b1 && c < 200) begin
                txfifo_full = ($urandom_range(0, 2) == 0);
                phases = 16'($urandom);
                tick();
                c++;
            end
            txfifo_full = 1'b0;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL rand_timeout%0d: busy=%b required 0", it, busy); else n_pass++;
        end
        tick();
        n_checks++;
        if (drop_count !== 8'(m_drops)) $display("FAIL rand_drop: got %0d required %0d", drop_count, m_drops); else n_pass++;
        txfifo_load = 13'd0;
        compare_streams("rand");
    endtask

    task automatic test_saturate;
        txfifo_load = 13'd4096;
        for (int i = 0; i < 260; i++) begin
            model_request();
            pulse_req();
        end
        tick();
        n_checks++;
        if (drop_count !== 8'(m_drops) || m_drops != 255)
            $display("FAIL saturate: got %0d required %0d", drop_count, m_drops);
        else n_pass++;
        txfifo_load = 13'd0;
    endtask

    task automatic test_reset_mid;
        got_q.delete(); exp_q.delete();
        tick();
        phases = 16'($urandom);
        pulse_req();
        tick(); tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (txfifo_wr !== 1'b0 || busy !== 1'b0 || txfifo_data !== 8'h00 || drop_count !== 8'h00)
            $display("FAIL rstmid_outputs: wr=%b busy=%b data=%h drop=%0d required 0 0 00 0",
                     txfifo_wr, busy, txfifo_data, drop_count);
        else n_pass++;
        rst = 1'b0;
        m_sticky = 1'b0; m_dflag = 1'b0; m_drops = 0;
        repeat (3) tick();
        n_checks++;
        if (got_q.size() != 3) $display("FAIL rstmid_truncated: got %0d bytes required 3", got_q.size()); else n_pass++;
        got_q.delete();
        phases = 16'($urandom);
        model_request(); pulse_req(); wait_idle("rstmid");
        compare_streams("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_sticky();
        test_space_drop();
        test_pending();
        test_random();
        test_saturate();
        test_reset_mid();
        n_checks++;
        if (wr_full_viol != 0) $display("FAIL wr_while_full: got %0d writes required 0", wr_full_viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
